// File: rtl/conv_mac_pipe_if.sv
// Operand/result stream bundle for conv_mac_pipe: an operand (a, b, last) channel in and a
// result (data, sat) channel out, each under valid/ready.
interface conv_mac_pipe_if #(
  parameter int unsigned A_WIDTH   = 16,
  parameter int unsigned B_WIDTH   = 8,
  parameter int unsigned OUT_WIDTH = 24
);
  logic                 in_valid;
  logic                 in_ready;
  logic [A_WIDTH-1:0]   in_a;
  logic [B_WIDTH-1:0]   in_b;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_sat;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/conv_mac_pipe.sv
// Pipelined signed MAC: per-window accumulation with saturation, one result per window.
// Optional macro CONV_MAC_RELU_EN clamps the final window value at zero before output.
module conv_mac_pipe #(
  parameter int unsigned A_WIDTH   = 16,
  parameter int unsigned B_WIDTH   = 8,
  parameter int unsigned NUM_STAGE = 3,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned OUT_WIDTH = 24
) (
  input  logic           clk,
  input  logic           reset,
  conv_mac_pipe_if.slave bus
);
  localparam int unsigned PW = A_WIDTH + B_WIDTH;

  localparam logic [ACC_WIDTH-1:0] AccMax = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] AccMin = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [OUT_WIDTH-1:0] OutMax = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OutMin = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic                 r_out_valid;
  logic [OUT_WIDTH-1:0] r_out_data;
  logic                 r_out_sat;
  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_first;
  logic                 r_win_sat;

  logic [PW-1:0]        r_prod [NUM_STAGE];
  logic [NUM_STAGE-1:0] r_pvld;
  logic [NUM_STAGE-1:0] r_plast;

  logic w_adv;
  assign w_adv        = !r_out_valid || bus.out_ready;
  assign bus.in_ready = w_adv;

  logic signed [PW-1:0] w_a_ext;
  logic signed [PW-1:0] w_b_ext;
  logic        [PW-1:0] w_prod;
  assign w_a_ext = $signed({{B_WIDTH{bus.in_a[A_WIDTH-1]}}, bus.in_a});
  assign w_b_ext = $signed({{A_WIDTH{bus.in_b[B_WIDTH-1]}}, bus.in_b});
  assign w_prod  = w_a_ext * w_b_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_STAGE; i++) begin
        r_prod[i] <= '0;
      end
      r_pvld  <= '0;
      r_plast <= '0;
    end else if (w_adv) begin
      r_prod[0]  <= w_prod;
      r_pvld[0]  <= bus.in_valid;
      r_plast[0] <= bus.in_last;
      for (int i = 1; i < NUM_STAGE; i++) begin
        r_prod[i]  <= r_prod[i-1];
        r_pvld[i]  <= r_pvld[i-1];
        r_plast[i] <= r_plast[i-1];
      end
    end
  end

  logic [PW-1:0]        w_p;
  logic                 w_pv;
  logic                 w_pl;
  logic [ACC_WIDTH-1:0] w_base;
  logic [ACC_WIDTH:0]   w_sum_wide;
  logic                 w_acc_ovf;
  logic [ACC_WIDTH-1:0] w_sum;
  logic [ACC_WIDTH-1:0] w_fin;
  logic                 w_out_ovf;
  logic [OUT_WIDTH-1:0] w_out;

  assign w_p  = r_prod[NUM_STAGE-1];
  assign w_pv = r_pvld[NUM_STAGE-1];
  assign w_pl = r_plast[NUM_STAGE-1];

  always_comb begin
    w_base     = r_first ? '0 : r_acc;
    // One guard bit is enough: both addends already lie in the ACC_WIDTH signed range.
    w_sum_wide = {w_base[ACC_WIDTH-1], w_base}
               + {{(ACC_WIDTH + 1 - PW){w_p[PW-1]}}, w_p};
    w_acc_ovf  = w_sum_wide[ACC_WIDTH] ^ w_sum_wide[ACC_WIDTH-1];
    w_sum      = w_acc_ovf ? (w_sum_wide[ACC_WIDTH] ? AccMin : AccMax)
                           : w_sum_wide[ACC_WIDTH-1:0];
`ifdef CONV_MAC_RELU_EN
    w_fin      = w_sum[ACC_WIDTH-1] ? '0 : w_sum;
`else
    w_fin      = w_sum;
`endif
    w_out_ovf  = !((&w_fin[ACC_WIDTH-1:OUT_WIDTH-1]) || !(|w_fin[ACC_WIDTH-1:OUT_WIDTH-1]));
    w_out      = w_out_ovf ? (w_fin[ACC_WIDTH-1] ? OutMin : OutMax) : w_fin[OUT_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc       <= '0;
      r_first     <= 1'b1;
      r_win_sat   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else if (w_adv) begin
      // Under w_adv any held result is being accepted, so valid simply tracks a new result.
      r_out_valid <= w_pv && w_pl;
      if (w_pv) begin
        if (w_pl) begin
          r_acc      <= '0;
          r_first    <= 1'b1;
          r_win_sat  <= 1'b0;
          r_out_data <= w_out;
          r_out_sat  <= r_win_sat | w_acc_ovf | w_out_ovf;
        end else begin
          r_acc     <= w_sum;
          r_first   <= 1'b0;
          r_win_sat <= r_win_sat | w_acc_ovf;
        end
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sat   = r_out_sat;
endmodule

// File: tb/tb_conv_mac_pipe.sv
// Randomised bench for conv_mac_pipe against a window-level arithmetic model.
module tb_conv_mac_pipe;
  localparam int unsigned AW   = 16;
  localparam int unsigned BW   = 8;
  localparam int unsigned NS   = 3;
  localparam int unsigned ACCW = 32;
  localparam int unsigned OW   = 24;

  localparam longint AccMax = (longint'(1) <<< (ACCW - 1)) - 1;
  localparam longint AccMin = -(longint'(1) <<< (ACCW - 1));
  localparam longint OutMax = (longint'(1) <<< (OW - 1)) - 1;
  localparam longint OutMin = -(longint'(1) <<< (OW - 1));

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  conv_mac_pipe_if #(.A_WIDTH(AW), .B_WIDTH(BW), .OUT_WIDTH(OW)) bus ();

  conv_mac_pipe #(
    .A_WIDTH(AW), .B_WIDTH(BW), .NUM_STAGE(NS), .ACC_WIDTH(ACCW), .OUT_WIDTH(OW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    longint data;
    bit     sat;
  } res_t;

  res_t   exp_q[$];
  longint m_acc   = 0;
  bit     m_first = 1'b1;
  bit     m_sat   = 1'b0;
  longint last_data = 0;
  bit     last_sat  = 1'b0;
  int     n_out     = 0;

  // Window-level reference: exact integer sum, clamped to the accumulator range per term.
  task automatic model_xfer(input longint a, input longint b, input bit last);
    longint s;
    longint f;
    bit     oc;
    s = (m_first ? 0 : m_acc) + a * b;
    if (s > AccMax) begin s = AccMax; m_sat = 1'b1; end
    if (s < AccMin) begin s = AccMin; m_sat = 1'b1; end
    if (last) begin
      f  = s;
`ifdef CONV_MAC_RELU_EN
      if (f < 0) f = 0;
`endif
      oc = 1'b0;
      if (f > OutMax) begin f = OutMax; oc = 1'b1; end
      if (f < OutMin) begin f = OutMin; oc = 1'b1; end
      exp_q.push_back('{data: f, sat: m_sat | oc});
      m_acc   = 0;
      m_first = 1'b1;
      m_sat   = 1'b0;
    end else begin
      m_acc   = s;
      m_first = 1'b0;
    end
  endtask

  bit     rnd_mode  = 1'b0;
  bit     rdy_fixed = 1'b1;
  always begin
    @(posedge clk);
    #1;
    bus.out_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : rdy_fixed;
  end

  bit     prev_hold = 1'b0;
  longint prev_data = 0;
  bit     prev_sat  = 1'b0;
  res_t   r;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_acc     = 0;
      m_first   = 1'b1;
      m_sat     = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", longint'(bus.out_valid), 1);
        check("hold_data", longint'($signed(bus.out_data)), prev_data);
        check("hold_sat", longint'(bus.out_sat), longint'(prev_sat));
      end
      check("in_ready", longint'(bus.in_ready), longint'(!bus.out_valid || bus.out_ready));
      if (bus.in_valid && bus.in_ready)
        model_xfer(longint'($signed(bus.in_a)), longint'($signed(bus.in_b)), bus.in_last);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_result", 1, 0);
        end else begin
          r = exp_q.pop_front();
          check("out_data", longint'($signed(bus.out_data)), r.data);
          check("out_sat", longint'(bus.out_sat), longint'(r.sat));
          last_data = longint'($signed(bus.out_data));
          last_sat  = bus.out_sat;
          n_out++;
        end
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_data = longint'($signed(bus.out_data));
      prev_sat  = bus.out_sat;
    end
  end

  task automatic send(input longint a, input longint b, input bit last);
    int w;
    w = 0;
    bus.in_a     = AW'(a);
    bus.in_b     = BW'(b);
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      w++;
      if (w > 200) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    rdy_fixed = 1'b1;
    while ((exp_q.size() != 0 || bus.out_valid) && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) check("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  function automatic longint pick_a();
    int unsigned k;
    k = $urandom_range(0, 7);
    if (k == 0) return OutMin >>> (OW - AW);
    if (k == 1) return (longint'(1) <<< (AW - 1)) - 1;
    return longint'($urandom_range(0, (1 << AW) - 1)) - (longint'(1) <<< (AW - 1));
  endfunction

  function automatic longint pick_b();
    int unsigned k;
    k = $urandom_range(0, 7);
    if (k == 0) return -(longint'(1) <<< (BW - 1));
    if (k == 1) return (longint'(1) <<< (BW - 1)) - 1;
    return longint'($urandom_range(0, (1 << BW) - 1)) - (longint'(1) <<< (BW - 1));
  endfunction

  int n;
  int base_out;
  int len;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_out_valid", longint'(bus.out_valid), 0);
    check("rst_out_data", longint'(bus.out_data), 0);
    check("rst_out_sat", longint'(bus.out_sat), 0);
    check("rst_in_ready", longint'(bus.in_ready), 1);
    @(posedge clk);
    #1;

    // Single-term window and its latency in clock edges, counting the transfer edge.
    send(-32768, -128, 1'b1);
    n = 1;
    forever begin
      @(negedge clk);
      if (bus.out_valid || n > 20) break;
      @(posedge clk);
      n++;
    end
    check("t1_latency", n, NS + 1);
    drain();
    check("t1_data", last_data, 4194304);
    check("t1_sat", longint'(last_sat), 0);

    send(100, 2, 1'b0);
    send(-50, 3, 1'b0);
    send(7, -1, 1'b1);
    send(1, 1, 1'b1);
    drain();
    check("t2_next_window", last_data, 1);

    send(100, 2, 1'b0);
    send(-50, 3, 1'b0);
    send(7, -1, 1'b1);
    drain();
    check("t2_data", last_data, 43);

    for (int i = 0; i < 3; i++) send(32767, 127, i == 2);
    drain();
    check("t3_data", last_data, 8388607);
    check("t3_sat", longint'(last_sat), 1);
    send(1, 1, 1'b1);
    drain();
    check("t3_next_sat", longint'(last_sat), 0);

    // Four short windows against a stalled output.
    base_out  = n_out;
    rdy_fixed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    fork
      begin
        for (int w = 0; w < 4; w++) begin
          send(w + 1, 2, 1'b0);
          send(-3, w + 5, 1'b1);
        end
      end
      begin
        repeat (10) @(posedge clk);
        rdy_fixed = 1'b1;
      end
    join
    drain();
    check("t4_count", n_out - base_out, 4);

    // Reset with a held result and a partial window in flight.
    rdy_fixed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send(5, 5, 1'b1);
    send(1, 1, 1'b0);
    send(2, 2, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    check("t5_pre_valid", longint'(bus.out_valid), 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("t5_rst_valid", longint'(bus.out_valid), 0);
    check("t5_rst_data", longint'(bus.out_data), 0);
    check("t5_rst_sat", longint'(bus.out_sat), 0);
    check("t5_rst_in_ready", longint'(bus.in_ready), 1);
    @(posedge clk);
    #2 reset = 1'b0;
    rdy_fixed = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send(3, 4, 1'b1);
    drain();
    check("t5_data", last_data, 12);

    send(7, -7, 1'b1);
    drain();
`ifdef CONV_MAC_RELU_EN
    check("t6_data", last_data, 0);
`else
    check("t6_data", last_data, -49);
`endif
    check("t6_sat", longint'(last_sat), 0);

    // Random windows under random backpressure and input gaps.
    rnd_mode = 1'b1;
    for (int w = 0; w < 60; w++) begin
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 4) == 0) begin
          @(posedge clk);
          #1;
        end
        send(pick_a(), pick_b(), k == len - 1);
      end
    end
    // Long windows drive the accumulator itself into both rails.
    for (int k = 0; k < 600; k++) send(32767, 127, k == 599);
    for (int k = 0; k < 600; k++) send(-32768, 127, k == 599);
    send(-32768, -128, 1'b1);
    rnd_mode = 1'b0;
    drain();
    check("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_mac_pipe.md
Name: conv_mac_pipe

Overview:
- Parametrised, pipelined signed multiply-accumulate unit for the CNN convolution datapath; the successor to the fixed-width combinational multiplier cores.
- Streams (a, b) operand pairs under a valid/ready handshake and multiplies them through a configurable register pipeline.
- Accumulates each window of products (window ended by in_last) and emits one saturated result per window.
- Sits between the line-buffer/weight readers and the output-activation writer of a conv layer.

Parameters:
- A_WIDTH, 16, signed width of activation operand a
- B_WIDTH, 8, signed width of weight operand b
- NUM_STAGE, 3, multiplier pipeline registers (legal range >= 1)
- ACC_WIDTH, 32, internal accumulator width (must be >= A_WIDTH+B_WIDTH)
- OUT_WIDTH, 24, result width (must be <= ACC_WIDTH)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair present
- in_ready  out  1  block accepts operand pair this cycle
- in_a  in  A_WIDTH  signed activation
- in_b  in  B_WIDTH  signed weight
- in_last  in  1  pair is the final term of the current window
- out_valid  out  1  result held on out_data
- out_ready  in  1  downstream accepts result
- out_data  out  OUT_WIDTH  signed window result
- out_sat  out  1  saturation occurred anywhere in this window

Behaviour:
- Global advance enable: adv = !out_valid || out_ready; in_ready = adv (combinational).
- When adv = 0, every pipeline register, the accumulator and the output register hold.
- Input transfer occurs when in_valid && in_ready.
- Multiplier pipeline:
  - p = signed(in_a) * signed(in_b), full A_WIDTH+B_WIDTH bits, no truncation.
  - Carried through NUM_STAGE registers together with valid and last sideband bits.
  - Bubbles (valid = 0) propagate and do not touch the accumulator.
- Accumulator stage (on adv with valid product):
  - sum = (first ? 0 : acc) + sign-extend(p).
  - sum is saturated to the ACC_WIDTH signed range; if clamped, set the window sat flag.
  - If last = 0: acc <= sum, first <= 0.
  - If last = 1: acc <= 0, first <= 1.
  - If last = 1: out_data <= sum saturated to the OUT_WIDTH signed range.
  - If last = 1: out_sat <= window sat flag OR output clamp; out_valid <= 1; window sat flag cleared.
- Output register:
  - out_valid && out_ready with no new result in the same cycle: out_valid <= 0; out_data and out_sat hold their values.
  - Accept and new result in the same cycle: out_valid stays 1 and the new data loads. No bubble, no loss.
  - out_data and out_sat are stable while out_valid && !out_ready.
- Latency: in_last transfer at cycle t -> out_valid at t+NUM_STAGE+1, absent stalls.
- Throughput: one pair per cycle while out_ready = 1.
- Windows of length 1 are legal: the result is p.
- There is no maximum window length; the accumulator saturates rather than wraps.
- Reset (asserted at any time, including mid-window):
  - All pipeline valid bits 0, acc 0, first 1, window sat flag 0.
  - out_valid 0, out_data 0, out_sat 0.
  - The partial window is discarded.
  - in_ready is 1 while reset is deasserted and out_valid = 0.

Optional Feature:
- Macro CONV_MAC_RELU_EN.
- Defined: the final window value is clamped at 0 from below before output saturation; negative sums give out_data = 0 and do not set out_sat. Latency is unchanged.
- Undefined: signed result passes through unchanged.

Test Plan (defaults: A=16, B=8, ACC=32, OUT=24, NUM_STAGE=3):
- Single pair (-32768, -128), last = 1 -> out_data = 4194304, out_sat = 0, out_valid exactly 4 cycles after the transfer.
- Window (100, 2), (-50, 3), (7, -1), last on the third pair, back-to-back -> out_data = 43, out_sat = 0; a following window (1, 1), last = 1 -> 1 (first-flag clear verified).
- Three pairs (32767, 127) in one window -> true sum 12484227 clamps to out_data = 8388607, out_sat = 1; next window (1, 1) -> out_sat = 0.
- Four 2-term windows streamed with out_ready = 0 for 10 cycles -> in_ready drops within 1 cycle of out_valid; out_data held stable; all four results delivered in order once out_ready = 1.
- Reset pulse after 2 terms of a window (reset deasserted between clock edges) -> out_valid = 0 immediately (asynchronous); next window (3, 4), last = 1 -> 12 (no residue).
- Window (7, -7), last = 1 -> out_data = -49 without CONV_MAC_RELU_EN; 0 with it, out_sat = 0 in both builds.
